// File: rtl/cpa_final_stage.sv
// Multi-cycle carry-propagate adder for the compressor tree's sum/carry rows, CHUNK bits/cycle.
// Define CPA_OVF_EN to expose the carry out of the MSB on the ovf port.
module cpa_final_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_row,
    input  logic [WIDTH-1:0] carry_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product
`ifdef CPA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("cpa_final_stage: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   car_q, car_d;
    logic [WIDTH-1:0]   product_q, product_d;
`ifdef CPA_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [31:0]        base;
    logic [CHUNK-1:0]   sum_c, car_c;
    logic [CHUNK:0]     add;
    logic [WIDTH-1:0]   mask;

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign product   = product_q;
`ifdef CPA_OVF_EN
    assign ovf       = ovf_q;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        car_d     = car_q;
        product_d = product_q;
`ifdef CPA_OVF_EN
        ovf_d     = ovf_q;
`endif
        base  = 32'(idx_q) * CHUNK;
        sum_c = CHUNK'(sum_q >> base);
        car_c = CHUNK'(car_q >> base);
        add   = {1'b0, sum_c} + {1'b0, car_c} + (CHUNK + 1)'(carry_q);
        mask  = '0;
        mask[CHUNK-1:0] = '1;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    sum_d   = sum_row;
                    car_d   = carry_row;
                    idx_d   = '0;
                    carry_d = 1'b0;
`ifdef CPA_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = StAdd;
                end
            end
            StAdd: begin
                // Overwrite only chunk idx of the result; other chunks hold.
                product_d = (product_q & ~(mask << base)) | (WIDTH'(add[CHUNK-1:0]) << base);
                carry_d   = add[CHUNK];
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = StDone;
`ifdef CPA_OVF_EN
                    ovf_d   = add[CHUNK];
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
            car_q     <= '0;
            product_q <= '0;
`ifdef CPA_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            sum_q     <= sum_d;
            car_q     <= car_d;
            product_q <= product_d;
`ifdef CPA_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_cpa_final_stage.sv
// Bench for cpa_final_stage: WIDTH=16 with CHUNK=4 (dut_a) and CHUNK=16 (dut_b).
module tb_cpa_final_stage;

    typedef struct packed {
        logic [15:0] prod;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_sum, a_car, a_product;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_sum, b_car, b_product;
`ifdef CPA_OVF_EN
    logic        a_ovf, b_ovf;
`endif

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cpa_final_stage #(.WIDTH(16), .CHUNK(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .sum_row   (a_sum),
        .carry_row (a_car),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .product   (a_product)
`ifdef CPA_OVF_EN
        ,
        .ovf       (a_ovf)
`endif
    );

    cpa_final_stage #(.WIDTH(16), .CHUNK(16)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .sum_row   (b_sum),
        .carry_row (b_car),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .product   (b_product)
`ifdef CPA_OVF_EN
        ,
        .ovf       (b_ovf)
`endif
    );

    function automatic exp_t model(input logic [15:0] s, input logic [15:0] c);
        logic [16:0] full;
        exp_t        e;
        full   = {1'b0, s} + {1'b0, c};
        e.prod = full[15:0];
        e.ovf  = full[16];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input string tag, input logic [15:0] s, input logic [15:0] c,
                          input bit keep, input int exp_wait);
        int n = 0;
        a_sum      = s;
        a_car      = c;
        a_in_valid = 1'b1;
        while (!a_in_ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_accept_wait"}, n, exp_wait);
        tick();
        if (!keep) a_in_valid = 1'b0;
        sb_a.push_back(model(s, c));
    endtask

    task automatic wait_a(input string tag, input int exp_lat);
        int lat = 0;
        while (!a_out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic take_a(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb_a.size() != 0), 1);
        if (sb_a.size() != 0) begin
            e = sb_a.pop_front();
            check({tag, "_product"}, a_product, e.prod);
`ifdef CPA_OVF_EN
            check({tag, "_ovf"}, a_ovf, e.ovf);
`endif
        end
        a_out_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, a_out_valid, 0);
    endtask

    initial begin
        exp_t        e;
        int          cnt;
        int          lat;
        logic [15:0] s, c;

        rst = 1'b1;
        a_in_valid = 0; a_out_ready = 1; a_sum = 0; a_car = 0;
        b_in_valid = 0; b_out_ready = 1; b_sum = 0; b_car = 0;
        tick();
        tick();
        check("rst_out_valid", a_out_valid, 0);
        check("rst_product", a_product, 0);
        check("rst_in_ready_low", a_in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", a_in_ready, 1);
        check("post_rst_b_out_valid", b_out_valid, 0);

        // 1: basic carry ripple across chunks
        send_a("t1", 16'h00FF, 16'h0001, 1'b0, 0);
        wait_a("t1", 4);
        take_a("t1");
        check("t1_in_ready", a_in_ready, 1);

        // 2: wrap to zero, carry out of MSB
        send_a("t2", 16'hFFFF, 16'h0001, 1'b0, 0);
        wait_a("t2", 4);
        take_a("t2");

        // 3: backpressure in DONE, with junk offered on the input
        a_out_ready = 1'b0;
        send_a("t3", 16'h0F0F, 16'h0101, 1'b0, 0);
        wait_a("t3", 4);
        e = sb_a[0];
        a_in_valid = 1'b1;
        a_sum      = 16'hDEAD;
        a_car      = 16'hBEEF;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t3_hold_valid", a_out_valid, 1);
            check("t3_hold_product", a_product, e.prod);
            check("t3_hold_in_ready", a_in_ready, 0);
        end
        a_in_valid = 1'b0;
        take_a("t3");
        check("t3_in_ready", a_in_ready, 1);

        // 4: reset on second ADD cycle discards the operation
        send_a("t4", 16'h1234, 16'h1111, 1'b0, 0);
        tick();
        rst = 1'b1;
        tick();
        check("t4_out_valid", a_out_valid, 0);
        check("t4_product", a_product, 0);
        check("t4_in_ready_in_rst", a_in_ready, 0);
        rst = 1'b0;
        #1;
        check("t4_in_ready", a_in_ready, 1);
        sb_a.delete();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_out_valid) cnt++;
        end
        check("t4_no_result", cnt, 0);

        // 5: back-to-back with in_valid held high
        send_a("t5a", 16'h1234, 16'h4321, 1'b1, 0);
        a_sum = 16'hA5A5;
        a_car = 16'h5A5A;
        wait_a("t5a", 4);
        check("t5_busy_in_ready", a_in_ready, 0);
        take_a("t5a");
        send_a("t5b", 16'hA5A5, 16'h5A5A, 1'b0, 0);
        wait_a("t5b", 4);
        take_a("t5b");

        // random operands
        for (int i = 0; i < 6; i++) begin
            s = 16'($urandom);
            c = 16'($urandom);
            send_a("rnd", s, c, 1'b0, 0);
            wait_a("rnd", 4);
            take_a("rnd");
        end

        // 6: CHUNK == WIDTH, single-cycle ADD
        for (int i = 0; i < 3; i++) begin
            s = (i == 0) ? 16'h8000 : 16'($urandom);
            c = (i == 0) ? 16'h8000 : 16'($urandom);
            b_sum      = s;
            b_car      = c;
            b_in_valid = 1'b1;
            cnt = 0;
            while (!b_in_ready && cnt < 40) begin
                tick();
                cnt++;
            end
            check("t6_accept_wait", cnt, 0);
            tick();
            b_in_valid = 1'b0;
            sb_b.push_back(model(s, c));
            lat = 0;
            while (!b_out_valid && lat < 40) begin
                tick();
                lat++;
            end
            check("t6_latency", lat, 1);
            e = sb_b.pop_front();
            check("t6_product", b_product, e.prod);
`ifdef CPA_OVF_EN
            check("t6_ovf", b_ovf, e.ovf);
`endif
            tick();
            check("t6_valid_drop", b_out_valid, 0);
        end

        check("sb_a_drained", sb_a.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
